// File: rtl/store_buffer.sv
// Posted-write FIFO between the MEM stage and the data memory's single write port.
// Drains the head store whenever the port is free and flags loads that hit a pending store word.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_addr,
    input  logic [31:0]      in_wdata,
    input  logic [2:0]       in_dmop,
    input  logic [31:0]      in_pc,
    input  logic             port_busy,
    output logic             dm_we,
    output logic [31:0]      dm_addr,
    output logic [31:0]      dm_wdata,
    output logic [2:0]       dm_dmop,
    output logic [31:0]      dm_pc,
    input  logic             ld_valid,
    input  logic [31:0]      ld_addr,
    output logic             ld_hazard,
    output logic [PTR_W:0]   count,
    output logic             empty,
    output logic             full
);

    logic [31:0]      r_addr  [DEPTH];
    logic [31:0]      r_wdata [DEPTH];
    logic [2:0]       r_dmop  [DEPTH];
    logic [31:0]      r_pc    [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W:0]   r_count;

    logic             w_push;
    logic             w_pop;
    logic             w_empty;
    logic             w_full;
    logic [DEPTH-1:0] w_hit;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == (PTR_W+1)'(DEPTH));
    assign in_ready = !w_full;
    assign w_push   = in_valid && !w_full && (in_dmop != 3'b000);
    assign w_pop    = !w_empty && !port_busy;

    assign dm_we    = w_pop;
    assign dm_addr  = w_empty ? 32'h0 : r_addr[r_head];
    assign dm_wdata = w_empty ? 32'h0 : r_wdata[r_head];
    assign dm_dmop  = w_empty ? 3'b000 : r_dmop[r_head];
    assign dm_pc    = w_empty ? 32'h0 : r_pc[r_head];

    assign count = r_count;
    assign empty = w_empty;
    assign full  = w_full;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [PTR_W-1:0] w_off;
            logic             w_valid;

            // An entry is live when its distance from head is below the occupancy.
            assign w_off     = PTR_W'(gi) - r_head;
            assign w_valid   = ({1'b0, w_off} < r_count);
            assign w_hit[gi] = w_valid && (r_addr[gi][13:2] == ld_addr[13:2]);

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_addr[gi]  <= 32'h0;
                    r_wdata[gi] <= 32'h0;
                    r_dmop[gi]  <= 3'b000;
                    r_pc[gi]    <= 32'h0;
                end else if (w_push && (r_tail == PTR_W'(gi))) begin
                    r_addr[gi]  <= in_addr;
                    r_wdata[gi] <= in_wdata;
                    r_dmop[gi]  <= in_dmop;
                    r_pc[gi]    <= in_pc;
                end
            end
        end
    endgenerate

    // The same-cycle push is deliberately excluded; the pipeline orders it ahead of the load.
    assign ld_hazard = ld_valid && (|w_hit);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + 1'b1;
            if (w_pop)  r_head <= r_head + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
